// File: rtl/quad_gearbox_pkg.sv
// quad_gearbox_pkg: quadrature decode result and step-FSM state encodings
package quad_gearbox_pkg;

    typedef enum logic [1:0] {DEC_NONE, DEC_INC, DEC_DEC, DEC_ERR} dec_e;
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW} state_e;

    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    // distance walked around the 00-01-11-10 cycle; two steps means both phases flipped
    function automatic dec_e quad_decode(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        d = gray_pos(cur) - gray_pos(prev);
        return d == 2'd1 ? DEC_INC : d == 2'd3 ? DEC_DEC : d == 2'd2 ? DEC_ERR : DEC_NONE;
    endfunction

endpackage

// File: rtl/quad_gearbox_if.sv
// quad_gearbox_if: encoder inputs, ratio configuration and step/dir outputs of one axis
interface quad_gearbox_if #(parameter int RATIO_W = 16);

    logic               en;
    logic               phase_a;
    logic               phase_b;
    logic               invert;
    logic [RATIO_W-1:0] ratio_num;
    logic [RATIO_W-1:0] ratio_den;
    logic               step;
    logic               dir;
    logic               phase_err;
    logic               ovf;
    logic               cfg_err;

    modport master (
        output en, phase_a, phase_b, invert, ratio_num, ratio_den,
        input  step, dir, phase_err, ovf, cfg_err
    );

    modport slave (
        input  en, phase_a, phase_b, invert, ratio_num, ratio_den,
        output step, dir, phase_err, ovf, cfg_err
    );

endinterface

// File: rtl/quad_gearbox_filter.sv
// quad_filter: two-flop synchroniser followed by a FILTER_LEN-sample stability filter
module quad_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_filt;
    logic          w_diff;
    logic          w_done;

    assign w_diff = r_sync[1] != r_filt;
    assign w_done = w_diff && r_cnt == CW'(FILTER_LEN - 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_cnt  <= (w_diff && !w_done) ? r_cnt + CW'(1) : '0;
            r_filt <= w_done ? r_sync[1] : r_filt;
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/quad_gearbox.sv
// quad_gearbox: quadrature encoder to step/dir converter at a programmable ratio num/den <= 1
module quad_gearbox
    import quad_gearbox_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int RATIO_W    = 16,
    parameter int PULSE_LEN  = 50,
    parameter int DIR_SETUP  = 25,
    parameter int BACKLOG_W  = 8
) (
    input logic           i_clk,
    input logic           i_rst_n,
    quad_gearbox_if.slave bus
);

    localparam int AW   = RATIO_W + 1;
    localparam int BW   = BACKLOG_W + 1;
    localparam int TMAX = PULSE_LEN > DIR_SETUP ? PULSE_LEN : DIR_SETUP;
    localparam int CW   = $clog2(TMAX + 1);
    localparam logic signed [BW-1:0] SAT_HI = BW'(2 ** (BACKLOG_W - 1) - 1);
    localparam logic signed [BW-1:0] SAT_LO = -SAT_HI;

    logic                        w_fa, w_fb;
    logic [1:0]                  r_prev, w_ab;
    dec_e                        w_dec;
    logic                        w_cfg_err, w_count, w_up, w_dn, w_inc, w_decr;
    logic [AW-1:0]               r_acc, w_acc_nxt, w_num, w_den, w_sum;
    logic signed [BACKLOG_W-1:0] r_backlog;
    logic signed [BW-1:0]        w_bl_ext, w_bl_sum;
    logic                        w_sat_hi, w_sat_lo;
    logic                        r_phase_err, r_ovf, r_dir;
    logic                        w_pos, w_neg, w_match, w_flip, w_take, w_dir_flip;
    state_e                      r_state, w_state_nxt;
    logic [CW-1:0]               r_cnt;

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_raw  (bus.phase_a),
        .o_filt (w_fa)
    );

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_raw  (bus.phase_b),
        .o_filt (w_fb)
    );

    assign w_ab  = {w_fa, w_fb};
    assign w_dec = quad_decode(r_prev, w_ab);

    assign w_cfg_err = bus.ratio_den == '0 || bus.ratio_num > bus.ratio_den;
    assign w_count   = bus.en && !w_cfg_err;
    assign w_num     = AW'(bus.ratio_num);
    assign w_den     = AW'(bus.ratio_den);
    assign w_sum     = r_acc + w_num;
    assign w_up      = w_sum >= w_den;
    assign w_dn      = r_acc < w_num;
    assign w_inc     = w_count && w_dec == DEC_INC && w_up;
    assign w_decr    = w_count && w_dec == DEC_DEC && w_dn;
    assign w_acc_nxt = !bus.en ? '0 :
                       !w_count ? r_acc :
                       w_dec == DEC_INC ? (w_up ? w_sum - w_den : w_sum) :
                       w_dec == DEC_DEC ? (w_dn ? r_acc + w_den - w_num : r_acc - w_num) :
                       r_acc;

    // decoder contribution and FSM consumption land in the same cycle as one net change
    assign w_bl_ext = {r_backlog[BACKLOG_W-1], r_backlog};
    assign w_bl_sum = w_bl_ext + BW'(w_inc) + BW'(w_take && !r_dir)
                    - BW'(w_decr) - BW'(w_take && r_dir);
    assign w_sat_hi = w_bl_sum > SAT_HI;
    assign w_sat_lo = w_bl_sum < SAT_LO;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev      <= '0;
            r_acc       <= '0;
            r_backlog   <= '0;
            r_phase_err <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_prev      <= w_ab;
            r_acc       <= w_acc_nxt;
            r_backlog   <= !bus.en ? '0 : w_sat_hi ? SAT_HI[BACKLOG_W-1:0] :
                           w_sat_lo ? SAT_LO[BACKLOG_W-1:0] : w_bl_sum[BACKLOG_W-1:0];
            r_phase_err <= r_phase_err | (bus.en && w_dec == DEC_ERR);
            r_ovf       <= r_ovf | (bus.en && (w_sat_hi || w_sat_lo));
        end
    end

    assign w_neg   = r_backlog[BACKLOG_W-1];
    assign w_pos   = !w_neg && r_backlog != '0;
    assign w_match = bus.en && (r_dir ? w_pos : w_neg);
    assign w_flip  = bus.en && (r_dir ? w_neg : w_pos);

    // LOW may chain straight into HIGH so a full backlog drains at one step per 2*PULSE_LEN
    always_comb begin
        w_state_nxt = r_state;
        w_dir_flip  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = w_match ? ST_HIGH : w_flip ? ST_SETUP : ST_IDLE;
                w_dir_flip  = !w_match && w_flip;
            end
            ST_SETUP: w_state_nxt = !bus.en ? ST_IDLE :
                                    r_cnt != CW'(DIR_SETUP - 1) ? ST_SETUP :
                                    w_match ? ST_HIGH : ST_IDLE;
            ST_HIGH:  w_state_nxt = r_cnt == CW'(PULSE_LEN - 1) ? ST_LOW : ST_HIGH;
            ST_LOW:   w_state_nxt = r_cnt != CW'(PULSE_LEN - 1) ? ST_LOW :
                                    w_match ? ST_HIGH : ST_IDLE;
        endcase
    end

    assign w_take = w_state_nxt == ST_HIGH && r_state != ST_HIGH;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_state_nxt != r_state || r_state == ST_IDLE) ? '0 : r_cnt + CW'(1);
            r_dir   <= r_dir ^ w_dir_flip;
        end
    end

    assign bus.step      = r_state == ST_HIGH;
    assign bus.dir       = r_dir ^ bus.invert;
    assign bus.phase_err = r_phase_err;
    assign bus.ovf       = r_ovf;
    assign bus.cfg_err   = w_cfg_err;

endmodule

// File: tb/tb_quad_gearbox.sv
// tb_quad_gearbox: random quadrature stimulus against a floor(num*pos/den) step model
module tb_quad_gearbox;

    localparam int FL  = 4;
    localparam int RW  = 8;
    localparam int PL  = 8;
    localparam int DS  = 3;
    localparam int BLW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    quad_gearbox_if #(.RATIO_W(RW)) bus ();

    quad_gearbox #(
        .FILTER_LEN(FL),
        .RATIO_W   (RW),
        .PULSE_LEN (PL),
        .DIR_SETUP (DS),
        .BACKLOG_W (BLW)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0, fwd = 0, rev = 0, width_bad = 0, setup_bad = 0, hi_len = 0, since_dir = 0;
    logic prev_step = 1'b0;
    logic prev_dir  = 1'b0;
    int rises[$];
    int pos = 0, mpos = 0, exp_fwd = 0, exp_rev = 0, rn = 1, rd = 1;
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_step = 1'b0;
            hi_len    = 0;
            since_dir = 0;
        end else begin
            since_dir = (bus.dir != prev_dir) ? 0 : since_dir + 1;
            if (bus.step) begin
                if (!prev_step) begin
                    if (bus.dir ^ bus.invert) fwd++;
                    else rev++;
                    if (since_dir < DS) setup_bad++;
                    rises.push_back(cyc);
                end
                hi_len++;
            end else if (prev_step) begin
                if (hi_len != PL) width_bad++;
                hi_len = 0;
            end
            prev_step = bus.step;
        end
        prev_dir = bus.dir;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        return (a % b != 0 && a < 0) ? q - 1 : q;
    endfunction

    task automatic set_ratio(input int n, input int d);
        rn = n;
        rd = d;
        bus.ratio_num = RW'(n);
        bus.ratio_den = RW'(d);
    endtask

    task automatic move(input int d);
        int m0;
        m0 = mpos;
        pos += d;
        {bus.phase_a, bus.phase_b} = gray[pos & 3];
        if (!bus.en) mpos = 0;
        else if (rd != 0 && rn <= rd) begin
            mpos += d;
            if (fdiv(rn * mpos, rd) > fdiv(rn * m0, rd)) exp_fwd++;
            else if (fdiv(rn * mpos, rd) < fdiv(rn * m0, rd)) exp_rev++;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run(input int n, input int d, input int gap);
        for (int i = 0; i < n; i++) begin
            move(d);
            wait_cyc(gap);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.phase_a = 1'b0;
        bus.phase_b = 1'b0;
        pos  = 0;
        mpos = 0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
    endtask

    int f0, r0, q0, n, mn, mx, iv;

    initial begin
        bus.en = 1'b1;
        bus.invert = 1'b0;
        bus.phase_a = 1'b0;
        bus.phase_b = 1'b0;
        set_ratio(1, 1);
        do_reset();
        chk("rst_step", bus.step, 0);
        chk("rst_dir", bus.dir, 0);
        chk("rst_phase_err", bus.phase_err, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("cfg_ok_1_1", bus.cfg_err, 0);
        bus.invert = 1'b1;
        #1 chk("invert_dir", bus.dir, 1);
        bus.invert = 1'b0;
        wait_cyc(2);

        f0 = fwd; r0 = rev; exp_fwd = 0; exp_rev = 0;
        run(100, 1, 20);
        wait_cyc(60);
        chk("t1_fwd", fwd - f0, exp_fwd);
        chk("t1_rev", rev - r0, exp_rev);
        chk("t1_dir", bus.dir, 1);
        chk("t1_phase_err", bus.phase_err, 0);

        move(1);
        n = 0;
        while (!bus.step && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency", n, FL + 4);
        wait_cyc(40);

        set_ratio(3, 8);
        do_reset();
        f0 = fwd; exp_fwd = 0; exp_rev = 0;
        run(80, 1, 20);
        wait_cyc(60);
        chk("t2_steps_80", fwd - f0, exp_fwd);
        f0 = fwd; exp_fwd = 0;
        run(3, 1, 20);
        wait_cyc(40);
        chk("t2_acc_zero", fwd - f0, exp_fwd);

        set_ratio(1, 1);
        do_reset();
        f0 = fwd; r0 = rev; exp_fwd = 0; exp_rev = 0;
        run(10, 1, 20);
        wait_cyc(60);
        chk("t3_fwd", fwd - f0, exp_fwd);
        run(10, -1, 20);
        wait_cyc(60);
        chk("t3_rev", rev - r0, exp_rev);
        chk("t3_dir", bus.dir, 0);

        set_ratio(1 + $urandom_range(0, 10), 12);
        set_ratio($urandom_range(0, rd), rd);
        do_reset();
        f0 = fwd; r0 = rev; exp_fwd = 0; exp_rev = 0;
        for (int i = 0; i < 60; i++) begin
            move(($urandom_range(0, 2) != 0) ? 1 : -1);
            wait_cyc(30 + $urandom_range(0, 10));
        end
        wait_cyc(60);
        chk("rand_fwd", fwd - f0, exp_fwd);
        chk("rand_rev", rev - r0, exp_rev);

        set_ratio(1, 1);
        do_reset();
        f0 = fwd; exp_fwd = 0;
        bus.en = 1'b0;
        run(5, 1, 20);
        bus.en = 1'b1;
        wait_cyc(5);
        run(3, 1, 20);
        wait_cyc(40);
        chk("en_steps", fwd - f0, exp_fwd);

        set_ratio(5, 4);
        do_reset();
        chk("cfg_err_5_4", bus.cfg_err, 1);
        f0 = fwd; r0 = rev;
        run(10, 1, 20);
        wait_cyc(40);
        chk("cfg_err_steps", (fwd - f0) + (rev - r0), 0);
        set_ratio(0, 0);
        #1 chk("cfg_err_den0", bus.cfg_err, 1);

        set_ratio(1, 1);
        do_reset();
        f0 = fwd; r0 = rev;
        for (int i = 0; i < 10; i++) begin
            bus.phase_a = 1'b1;
            wait_cyc(1);
            bus.phase_a = 1'b0;
            wait_cyc(10);
        end
        bus.phase_b = 1'b1;
        wait_cyc(FL - 1);
        bus.phase_b = 1'b0;
        wait_cyc(30);
        chk("glitch_steps", (fwd - f0) + (rev - r0), 0);
        chk("glitch_phase_err", bus.phase_err, 0);
        bus.phase_a = 1'b1;
        bus.phase_b = 1'b1;
        pos = 2;
        wait_cyc(30);
        chk("double_phase_err", bus.phase_err, 1);
        chk("double_steps", (fwd - f0) + (rev - r0), 0);

        f0 = fwd; q0 = rises.size();
        run(40, 1, 10);
        wait_cyc(300);
        chk("sat_ovf", bus.ovf, 1);
        chk("sat_dropped", int'(fwd - f0 < 40), 1);
        chk("sat_enough", int'(fwd - f0 >= 20), 1);
        chk("sticky_phase_err", bus.phase_err, 1);
        mn = 1 << 30;
        mx = 0;
        for (int i = q0 + 1; i < rises.size(); i++) begin
            iv = rises[i] - rises[i-1];
            mn = iv < mn ? iv : mn;
            mx = iv > mx ? iv : mx;
        end
        chk("sat_min_interval", mn, 2 * PL);
        chk("sat_max_interval", mx, 2 * PL);

        move(1);
        n = 0;
        while (!bus.step && n < 60) begin
            wait_cyc(1);
            n++;
        end
        chk("rh_step_seen", bus.step, 1);
        wait_cyc(1);
        #2 rst_n = 1'b0;
        #1;
        chk("rh_step", bus.step, 0);
        chk("rh_dir", bus.dir, 0);
        chk("rh_phase_err", bus.phase_err, 0);
        chk("rh_ovf", bus.ovf, 0);
        wait_cyc(2);
        bus.phase_a = 1'b0;
        bus.phase_b = 1'b0;
        rst_n = 1'b1;
        wait_cyc(5);

        chk("pulse_width", width_bad, 0);
        chk("dir_setup", setup_bad, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
